// File: rtl/imem_boot_ctrl_pkg.sv
// Shared configuration for the instruction-memory boot controller:
// FSM state encoding, the NOP instruction word and the default geometry.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (trailing checksum word).
package imem_boot_ctrl_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;

  // addi x0, x0, 0 -- what the CPU sees whenever it must not execute RAM data
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RESTART = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  // A fetch address is usable only if word aligned and inside the RAM window.
  function automatic logic pc_in_range(input logic [31:0] pc, input int aw);
    return (pc[1:0] == 2'b00) && ((pc >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader word stream. valid/ready semantics: a word moves on every rising
// clock edge where ld_valid && ld_ready; the master holds ld_data stable while
// ld_valid is high, and ld_ready may be driven without looking at ld_valid.
interface imem_boot_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/imem_csum.sv
// 32-bit wrapping sum of loaded words; only built with IMEM_LOAD_CHECKSUM_EN.
module imem_csum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sum
);

  // Accumulator: clear at load start, add each accepted data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sum <= 32'd0;
    else if (clr) sum <= 32'd0;
    else if (en)  sum <= sum + din;
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: serves CPU fetches from RAM in RUN,
// streams a program into RAM on request, then pulses cpu_restart.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds CHECK/FAIL states and a
// trailing checksum word that must match the wrapping sum of the data words.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_req,
  input  logic [AW:0]          load_len,
  imem_boot_ctrl_if.slave      ld,
  input  logic [31:0]          cpu_pc,
  output logic [31:0]          cpu_instr,
  output logic                 cpu_stall,
  output logic                 cpu_restart,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 busy,
  output logic                 err,
  output state_t               dbg_state
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_t        state, next_state;
  logic [AW-1:0] cnt;
  logic [AW:0]   len;
  logic          err_q;
  logic          start_load, cnt_inc, err_set;
  logic          len_ok, last_word, can_start;

  assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
  // Counter stops on the last word instead of stepping past it.
  assign last_word = ({1'b0, cnt} == (len - ONE_L));
  assign err       = err_q;
  assign dbg_state = state;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum;

  assign can_start = (state == ST_RUN) || (state == ST_FAIL);

  imem_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_load),
    .en    ((state == ST_LOAD) && ld.ld_valid),
    .din   (ld.ld_data),
    .sum   (sum)
  );
`else
  assign can_start = (state == ST_RUN);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  // Load length, word counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      len   <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_load) begin
        cnt <= '0;
        len <= load_len;
      end else if (cnt_inc) begin
        cnt <= cnt + AW'(1);
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // Next state and all outputs; stalled/busy unless explicitly in RUN.
  always_comb begin
    next_state  = state;
    cpu_instr   = NOP;
    cpu_stall   = 1'b1;
    busy        = 1'b1;
    cpu_restart = 1'b0;
    ld.ld_ready = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = cnt;
    mem_wdata   = ld.ld_data;
    start_load  = 1'b0;
    cnt_inc     = 1'b0;
    err_set     = 1'b0;

    case (state)
      ST_RUN: begin
        cpu_stall = 1'b0;
        busy      = 1'b0;
        mem_addr  = cpu_pc[AW+1:2];
        if (pc_in_range(cpu_pc, AW)) cpu_instr = mem_rdata;
        else                         err_set   = 1'b1;
      end
      ST_LOAD: begin
        ld.ld_ready = 1'b1;
        if (ld.ld_valid) begin
          mem_we = 1'b1;
          if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            next_state = ST_CHECK;
`else
            next_state = ST_RESTART;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        ld.ld_ready = 1'b1;
        if (ld.ld_valid) begin
          if (ld.ld_data == sum) begin
            next_state = ST_RESTART;
          end else begin
            err_set    = 1'b1;
            next_state = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        next_state = ST_FAIL;
      end
`endif
      ST_RESTART: begin
        cpu_restart = 1'b1;
        next_state  = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase

    // A new load may begin from RUN (and from FAIL when checksums exist).
    if (can_start && load_req) begin
      if (len_ok) begin
        start_load = 1'b1;
        next_state = ST_LOAD;
      end else begin
        err_set = 1'b1;
      end
    end
  end

endmodule
